// File: rtl/arith_mmio_seq.sv
// arith_mmio_seq: memory-mapped integer coprocessor with ADD, SUB, MULU and DIVU.
// Ports: clk/reset (async, active-high); chip_select, we, addr and data_in form the bus access;
//        data_out is the registered read data (one cycle of latency); irq = STATUS.done & CMD.irq_en.
// Latency: ADD/SUB take 1 cycle, MULU takes MUL_LAT cycles, DIVU takes DATA_W cycles (1 cycle when B=0).
module arith_mmio_seq #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 13,
   parameter int MUL_LAT = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              chip_select,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              irq
);

   localparam int PW = 2 * DATA_W;

   localparam logic [5:0] REG_A      = 6'h00;
   localparam logic [5:0] REG_B      = 6'h04;
   localparam logic [5:0] REG_CMD    = 6'h08;
   localparam logic [5:0] REG_STATUS = 6'h0C;
   localparam logic [5:0] REG_RES_LO = 6'h10;
   localparam logic [5:0] REG_RES_HI = 6'h14;

   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_MULU = 4'd3;
   localparam logic [3:0] OP_DIVU = 4'd4;

   typedef enum logic [1:0] {IDLE, ALU, MUL, DIV} state_t;

   state_t            state;
   logic [DATA_W-1:0] a_reg, b_reg;
   logic [DATA_W-1:0] op_a, op_b;
   logic [3:0]        op_code;
   logic [3:0]        cmd_op;
   logic              irq_en;
   logic              st_busy, st_done, st_div0, st_ovr, st_ill;
   logic [DATA_W-1:0] res_lo, res_hi;
   logic [15:0]       cnt;
   logic [DATA_W-1:0] rem, quo;

   logic [5:0]        reg_sel;
   logic              wr, rd, cmd_wr, stat_wr, legal, irq_en_in;
   logic [3:0]        opcode_in;
   logic [DATA_W:0]   add_sum, sub_dif;
   logic [PW-1:0]     mul_full, mul_tap;
   logic [DATA_W:0]   div_shift, div_sub;
   logic              div_ge;
   logic [DATA_W-1:0] rem_nxt, quo_nxt;
   logic [DATA_W-1:0] rd_val;
   logic              unused_bits;

   assign reg_sel   = addr[5:0];
   assign wr        = chip_select & we;
   assign rd        = chip_select & ~we;
   assign cmd_wr    = wr && (reg_sel == REG_CMD);
   assign stat_wr   = wr && (reg_sel == REG_STATUS);
   assign opcode_in = data_in[3:0];
   assign legal     = (opcode_in >= OP_ADD) && (opcode_in <= OP_DIVU);

   // irq_en lives in bit 8, which does not exist on an 8-bit bus.
   generate
      if (DATA_W > 8) begin : g_irq_bit
         assign irq_en_in = data_in[8];
      end else begin : g_irq_none
         assign irq_en_in = 1'b0;
      end
   endgenerate

   assign add_sum  = {1'b0, op_a} + {1'b0, op_b};
   assign sub_dif  = {1'b0, op_a} - {1'b0, op_b};   // bit DATA_W is the borrow
   assign mul_full = PW'(op_a) * PW'(op_b);

   // Multiplier pipeline: the operand regs hold still during MUL, so the tap
   // seen at edge N+MUL_LAT carries the product of the operands latched at N.
   generate
      if (MUL_LAT == 1) begin : g_mul_comb
         assign mul_tap = mul_full;
      end else begin : g_mul_pipe
         logic [PW-1:0] pipe [MUL_LAT-1];
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < MUL_LAT - 1; i++) pipe[i] <= '0;
            end else begin
               pipe[0] <= mul_full;
               for (int i = 1; i < MUL_LAT - 1; i++) pipe[i] <= pipe[i-1];
            end
         end
         assign mul_tap = pipe[MUL_LAT-2];
      end
   endgenerate

   // Restoring division step: shift the next dividend bit into the partial
   // remainder and subtract the divisor when it fits.
   assign div_shift = {rem, quo[DATA_W-1]};
   assign div_ge    = div_shift >= {1'b0, op_b};
   assign div_sub   = div_shift - {1'b0, op_b};
   assign rem_nxt   = div_ge ? div_sub[DATA_W-1:0] : div_shift[DATA_W-1:0];
   assign quo_nxt   = {quo[DATA_W-2:0], div_ge};

   assign unused_bits = ^{addr[ADDR_W-1:6], div_sub[DATA_W]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         a_reg   <= '0;
         b_reg   <= '0;
         op_a    <= '0;
         op_b    <= '0;
         op_code <= '0;
         cmd_op  <= '0;
         irq_en  <= 1'b0;
         st_busy <= 1'b0;
         st_done <= 1'b0;
         st_div0 <= 1'b0;
         st_ovr  <= 1'b0;
         st_ill  <= 1'b0;
         res_lo  <= '0;
         res_hi  <= '0;
         cnt     <= '0;
         rem     <= '0;
         quo     <= '0;
      end else begin
         if (wr) begin
            case (reg_sel)
               REG_A:   a_reg <= data_in;
               REG_B:   b_reg <= data_in;
               REG_CMD: begin
                  cmd_op <= opcode_in;
                  irq_en <= irq_en_in;
               end
               default: ;
            endcase
         end

         // W1C clears come first so a same-cycle completion set below wins.
         if (stat_wr) begin
            if (data_in[1]) st_done <= 1'b0;
            if (data_in[2]) st_div0 <= 1'b0;
            if (data_in[3]) st_ovr  <= 1'b0;
            if (data_in[4]) st_ill  <= 1'b0;
         end

         if (cmd_wr && (state != IDLE)) st_ovr <= 1'b1;

         case (state)
            IDLE: begin
               if (cmd_wr) begin
                  if (legal) begin
                     op_a    <= a_reg;
                     op_b    <= b_reg;
                     op_code <= opcode_in;
                     st_busy <= 1'b1;
                     st_done <= 1'b0;
                     st_div0 <= 1'b0;
                     cnt     <= '0;
                     rem     <= '0;
                     quo     <= a_reg;
                     if (opcode_in == OP_MULU)
                        state <= MUL;
                     else if ((opcode_in == OP_DIVU) && (b_reg != '0))
                        state <= DIV;
                     else
                        state <= ALU;   // ADD, SUB, or DIVU by zero
                  end else begin
                     st_ill <= 1'b1;
                  end
               end
            end
            ALU: begin
               case (op_code)
                  OP_ADD: begin
                     res_lo <= add_sum[DATA_W-1:0];
                     res_hi <= DATA_W'(add_sum[DATA_W]);
                  end
                  OP_SUB: begin
                     res_lo <= sub_dif[DATA_W-1:0];
                     res_hi <= DATA_W'(sub_dif[DATA_W]);
                  end
                  default: begin
                     res_lo  <= '1;
                     res_hi  <= op_a;
                     st_div0 <= 1'b1;
                  end
               endcase
               st_busy <= 1'b0;
               st_done <= 1'b1;
               state   <= IDLE;
            end
            MUL: begin
               if (cnt == 16'(MUL_LAT - 1)) begin
                  {res_hi, res_lo} <= mul_tap;
                  st_busy <= 1'b0;
                  st_done <= 1'b1;
                  state   <= IDLE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            DIV: begin
               rem <= rem_nxt;
               quo <= quo_nxt;
               if (cnt == 16'(DATA_W - 1)) begin
                  res_lo  <= quo_nxt;
                  res_hi  <= rem_nxt;
                  st_busy <= 1'b0;
                  st_done <= 1'b1;
                  state   <= IDLE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      rd_val = '0;
      case (reg_sel)
         REG_A:      rd_val = a_reg;
         REG_B:      rd_val = b_reg;
         REG_CMD:    rd_val = DATA_W'({23'd0, irq_en, 4'd0, cmd_op});
         REG_STATUS: rd_val = DATA_W'({27'd0, st_ill, st_ovr, st_div0, st_done, st_busy});
         REG_RES_LO: rd_val = res_lo;
         REG_RES_HI: rd_val = res_hi;
         default:    rd_val = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)   data_out <= '0;
      else if (rd) data_out <= rd_val;
   end

   assign irq = st_done & irq_en;

endmodule

// File: doc/arith_mmio_seq.md
Name: arith_mmio_seq

Overview:
Memory-mapped integer arithmetic coprocessor on the processor peripheral bus. It is the parametrised successor to the single-cycle add/sub/mul register block. It adds:
- explicit read/write decoding and a registered read path
- a pipelined multiplier with full double-width product
- a multi-cycle restoring unsigned divider
- busy/done/error status and an interrupt

Commands run under an FSM, and software polls STATUS or waits for irq.

Parameters:
DATA_W, 32, operand/bus width; 8..32.
ADDR_W, 13, bus address width; only addr[5:0] decoded.
MUL_LAT, 3, multiply latency in cycles; >=1.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
chip_select  in  1  bus access qualifier.
we  in  1  1=write, 0=read (valid with chip_select).
addr  in  ADDR_W  byte address; addr[5:0] selects register.
data_in  in  DATA_W  write data.
data_out  out  DATA_W  registered read data.
irq  out  1  = STATUS.done & irq_en.

Behaviour:
Register map (addr[5:0]):
- 0x00 A (RW)
- 0x04 B (RW)
- 0x08 CMD (RW): [3:0] opcode, [8] irq_en
- 0x0C STATUS (R; W1C on bits 1-4): [0] busy, [1] done, [2] div0, [3] overrun, [4] illegal
- 0x10 RES_LO (R)
- 0x14 RES_HI (R)
- Others: read 0, writes ignored.

Reads:
- On an edge with chip_select & !we, data_out <= selected register.
- Otherwise data_out holds. One-cycle read latency.

Opcodes:
- 1 ADD: LO=A+B; HI=carry-out in bit0.
- 2 SUB: LO=A-B; HI=borrow in bit0.
- 3 MULU: {HI,LO}=A*B unsigned, 2*DATA_W bits.
- 4 DIVU: LO=A/B, HI=A%B.
- 0 and 5..15: illegal.

FSM states: IDLE, ALU, MUL, DIV.
- At CMD-write edge N in IDLE with a legal opcode:
  - Latch A, B, opcode into internal operand regs.
  - Set busy=1; clear done, div0.
  - Go to ALU, MUL or DIV according to opcode.
- ALU: results written, busy=0, done=1 at edge N+1.
- MUL: counter runs MUL_LAT cycles; results, busy=0, done=1 at edge N+MUL_LAT.
- DIV: restoring divider, one quotient bit per cycle; complete at edge N+DATA_W.
- DIVU with B=0: LO=all ones, HI=A, div0=1, done=1 at edge N+1; DIV not entered.
- Illegal opcode at edge N: illegal=1, no busy, done/results unchanged.

Other rules:
- CMD write while busy: command ignored, overrun=1, running operation unaffected.
- A/B writes while busy: allowed; do not affect the running operation.
- RES_LO/RES_HI: change only on completion; hold until next completion.
- STATUS write:
  - 1 in bits 1..4 clears those bits; bit0 unaffected.
  - A same-cycle completion set wins over clear.
- irq: combinational from registered done and CMD[8].

Reset (any time, including mid-operation):
- All registers, counters and data_out go to 0; FSM to IDLE; irq=0.
- An in-flight result is discarded.

Test Plan:
1. ADD, DATA_W=32: A=5, B=7, CMD=1 -> busy=1 for 1 cycle; RES_LO=12, RES_HI=0, done=1. Then A=0xFFFFFFFF, B=1 -> LO=0, HI=1.
2. MULU, MUL_LAT=3: A=0x00010000, B=0x00010000, CMD=0x103 -> busy 3 cycles; LO=0, HI=1; irq=1 at completion. STATUS write 0x2 -> done=0, irq=0.
3. DIVU: A=100, B=7, CMD=4 -> busy exactly 32 cycles; LO=14, HI=2. Then B=0 -> LO=0xFFFFFFFF, HI=100, div0=1 after 1 cycle.
4. CMD=1 issued during a running DIVU -> overrun=1, DIVU result correct. CMD=9 in IDLE -> illegal=1, busy stays 0, results unchanged.
5. Assert reset 10 cycles into a DIVU -> all STATUS bits 0, RES_LO/HI 0, data_out 0, irq 0. A new ADD afterwards completes normally.
6. Reads: unmapped addr 0x20 -> data_out=0 one cycle later. data_out holds when chip_select=0. A write to RES_LO has no effect.
